// File: rtl/checkout_if.sv
// checkout_if: bundle between the checkout front end and checkout_marker.
//
// The master side drives the scan, upc, pay, cancel and tag_ready inputs.
// The slave side (checkout_marker) drives:
//   - the tag write channel: tag_valid, tag_upc, tag_mark, tag_disc;
//   - the status outputs: item_count, disc_count, full, busy, done.
interface checkout_if #(
  parameter int CW = 4
);
  logic          scan;
  logic [2:0]    upc;
  logic          pay;
  logic          cancel;
  logic          tag_ready;
  logic          tag_valid;
  logic [2:0]    tag_upc;
  logic          tag_mark;
  logic          tag_disc;
  logic [CW-1:0] item_count;
  logic [CW-1:0] disc_count;
  logic          full;
  logic          busy;
  logic          done;

  modport master (
    output scan, upc, pay, cancel, tag_ready,
    input  tag_valid, tag_upc, tag_mark, tag_disc,
    input  item_count, disc_count, full, busy, done
  );

  modport slave (
    input  scan, upc, pay, cancel, tag_ready,
    output tag_valid, tag_upc, tag_mark, tag_disc,
    output item_count, disc_count, full, busy, done
  );
endinterface

// File: rtl/checkout_marker.sv
// checkout_marker: point-of-sale cart buffer and tag marker.
//
// Buffers up to DEPTH scanned item codes {U,P,C} in a FIFO. On pay it streams
// one tag write per item (mark = 1) over a valid/ready handshake, in scan
// order. It also reports each item's discount flag, P | (U & C), and keeps a
// running count of discounted items for the transaction.
//
// Ports:
//   clk    - system clock, rising edge active
//   reset  - synchronous, active-high
//   bus    - checkout_if.slave:
//              inputs:  scan, upc, pay, cancel, tag_ready
//              outputs: tag_valid, tag_upc, tag_mark, tag_disc,
//                       item_count, disc_count, full, busy, done
module checkout_marker #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic       clk,
  input  logic       reset,
  checkout_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CART  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] item_count;
  logic [CW-1:0] disc_count;
  logic [2:0]    head;
  logic          at_cap;
  logic          accept;
  logic          xfer;
  logic          draining;

  function automatic logic disc(input logic [2:0] code);
    return code[1] | (code[2] & code[0]);
  endfunction

  assign at_cap   = (item_count == CW'(DEPTH));
  assign draining = (state == S_DRAIN);
  assign xfer     = draining && bus.tag_ready;

  // A scan is stored in IDLE, or in CART when there is room and no cancel
  // competes with it in the same cycle.
  assign accept = bus.scan &&
                  ((state == S_IDLE) ||
                   ((state == S_CART) && !bus.cancel && !at_cap));

  // Item storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.upc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      item_count <= '0;
      disc_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            wr_ptr     <= wr_ptr + PW'(1);
            item_count <= CW'(1);
            disc_count <= disc_count + CW'(disc(bus.upc));
            state      <= S_CART;
          end
        end
        S_CART: begin
          if (bus.cancel) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            item_count <= '0;
            disc_count <= '0;
          end else begin
            // A scan alongside pay is stored first and drained with the rest.
            if (accept) begin
              wr_ptr     <= wr_ptr + PW'(1);
              item_count <= item_count + CW'(1);
              disc_count <= disc_count + CW'(disc(bus.upc));
            end
            if (bus.pay) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            rd_ptr     <= rd_ptr + PW'(1);
            item_count <= item_count - CW'(1);
            if (item_count == CW'(1)) state <= S_DONE;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          disc_count <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag fields are forced to zero outside DRAIN so stale FIFO data never shows.
  assign head           = mem[rd_ptr];
  assign bus.tag_valid  = draining;
  assign bus.tag_mark   = draining;
  assign bus.tag_upc    = draining ? head : 3'b000;
  assign bus.tag_disc   = draining & disc(head);
  assign bus.item_count = item_count;
  assign bus.disc_count = disc_count;
  assign bus.full       = ((state == S_IDLE) || (state == S_CART)) && at_cap;
  assign bus.busy       = draining;
  assign bus.done       = (state == S_DONE);

endmodule

// File: tb/tb_checkout_marker.sv
// Directed testbench for checkout_marker (DEPTH = 8, CW = 4).
module tb_checkout_marker;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  checkout_if #(.CW(4)) bus ();

  checkout_marker #(.DEPTH(8), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time
  // unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_item(input logic [2:0] u);
    bus.scan = 1'b1;
    bus.upc  = u;
    step();
    bus.scan = 1'b0;
  endtask

  task automatic expect_tag(input string tag, input int u, input int d, input int cnt);
    check({tag, "_valid"}, int'(bus.tag_valid), 1);
    check({tag, "_mark"},  int'(bus.tag_mark),  1);
    check({tag, "_upc"},   int'(bus.tag_upc),   u);
    check({tag, "_disc"},  int'(bus.tag_disc),  d);
    check({tag, "_cnt"},   int'(bus.item_count), cnt);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, int'(bus.tag_valid),  0);
    check({tag, "_busy"},  int'(bus.busy),       0);
    check({tag, "_cnt"},   int'(bus.item_count), 0);
    check({tag, "_disc"},  int'(bus.disc_count), 0);
    check({tag, "_done"},  int'(bus.done),       0);
  endtask

  // Discount flag per 3-bit code, indexed by code: 111,110,101,011,010 -> 1.
  logic [7:0] disc_tab;

  initial begin
    disc_tab      = 8'b1110_1100;
    reset         = 1'b1;
    bus.scan      = 1'b0;
    bus.upc       = 3'b000;
    bus.pay       = 1'b0;
    bus.cancel    = 1'b0;
    bus.tag_ready = 1'b0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    expect_idle("rst");
    check("rst_full", int'(bus.full), 0);
    check("rst_upc", int'(bus.tag_upc), 0);
    check("rst_mark", int'(bus.tag_mark), 0);

    // Basic transaction: 101, 010, 001
    scan_item(3'b101);
    check("t1_cnt1", int'(bus.item_count), 1);
    check("t1_disc1", int'(bus.disc_count), 1);
    scan_item(3'b010);
    scan_item(3'b001);
    check("t1_cnt3", int'(bus.item_count), 3);
    check("t1_disc3", int'(bus.disc_count), 2);
    bus.pay = 1'b1;
    bus.tag_ready = 1'b1;
    step();
    bus.pay = 1'b0;
    check("t1_busy", int'(bus.busy), 1);
    expect_tag("t1_tag0", 5, 1, 3);
    step();
    expect_tag("t1_tag1", 2, 1, 2);
    step();
    expect_tag("t1_tag2", 1, 0, 1);
    // Scan presented during the DONE cycle must be ignored.
    bus.scan = 1'b1;
    bus.upc  = 3'b111;
    step();
    check("t1_done", int'(bus.done), 1);
    check("t1_done_valid", int'(bus.tag_valid), 0);
    check("t1_done_disc", int'(bus.disc_count), 2);
    check("t1_done_cnt", int'(bus.item_count), 0);
    step();
    bus.scan = 1'b0;
    expect_idle("t1_after");

    // Capacity: nine scans, ninth dropped
    for (int i = 0; i < 9; i++) begin
      scan_item(3'(i));
      if (i == 7) begin
        check("t2_full8", int'(bus.full), 1);
        check("t2_cnt8", int'(bus.item_count), 8);
      end
    end
    check("t2_full9", int'(bus.full), 1);
    check("t2_cnt9", int'(bus.item_count), 8);
    check("t2_disc", int'(bus.disc_count), 5);
    bus.pay = 1'b1;
    step();
    bus.pay = 1'b0;
    check("t2_full_drain", int'(bus.full), 0);
    for (int k = 0; k < 8; k++) begin
      expect_tag($sformatf("t2_tag%0d", k), k, int'(disc_tab[k]), 8 - k);
      step();
    end
    check("t2_done", int'(bus.done), 1);
    check("t2_done_disc", int'(bus.disc_count), 5);
    step();
    expect_idle("t2_after");

    // Backpressure in mid-drain: 011, 110, 100
    scan_item(3'b011);
    scan_item(3'b110);
    scan_item(3'b100);
    bus.pay = 1'b1;
    step();
    bus.pay = 1'b0;
    expect_tag("t3_tag0", 3, 1, 3);
    step();
    bus.tag_ready = 1'b0;
    expect_tag("t3_tag1", 6, 1, 2);
    for (int k = 0; k < 5; k++) begin
      step();
      expect_tag($sformatf("t3_hold%0d", k), 6, 1, 2);
    end
    bus.tag_ready = 1'b1;
    step();
    expect_tag("t3_tag2", 4, 0, 1);
    step();
    check("t3_done", int'(bus.done), 1);
    step();
    expect_idle("t3_after");

    // Scan together with pay: 001, 111, then 100 + pay
    scan_item(3'b001);
    scan_item(3'b111);
    bus.scan = 1'b1;
    bus.upc  = 3'b100;
    bus.pay  = 1'b1;
    step();
    bus.scan = 1'b0;
    bus.pay  = 1'b0;
    check("t4_disc", int'(bus.disc_count), 1);
    expect_tag("t4_tag0", 1, 0, 3);
    step();
    expect_tag("t4_tag1", 7, 1, 2);
    step();
    expect_tag("t4_tag2", 4, 0, 1);
    step();
    check("t4_done", int'(bus.done), 1);
    step();
    expect_idle("t4_after");

    // Scan together with cancel, and pay ignored in IDLE
    scan_item(3'b010);
    check("t5_cnt1", int'(bus.item_count), 1);
    bus.scan   = 1'b1;
    bus.upc    = 3'b111;
    bus.cancel = 1'b1;
    step();
    bus.scan   = 1'b0;
    bus.cancel = 1'b0;
    expect_idle("t5_cancel");
    bus.pay = 1'b1;
    step();
    bus.pay = 1'b0;
    expect_idle("t5_pay_idle");
    step();
    expect_idle("t5_quiet");

    // Reset during drain of 4 items, then a fresh 1-item transaction
    scan_item(3'b101);
    scan_item(3'b010);
    scan_item(3'b011);
    scan_item(3'b110);
    bus.pay = 1'b1;
    step();
    bus.pay = 1'b0;
    expect_tag("t6_tag0", 5, 1, 4);
    step();
    expect_tag("t6_tag1", 2, 1, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_idle("t6_rst");
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t6_nodone%0d", k), int'(bus.done), 0);
      check($sformatf("t6_novalid%0d", k), int'(bus.tag_valid), 0);
    end
    scan_item(3'b111);
    check("t6_new_cnt", int'(bus.item_count), 1);
    bus.pay = 1'b1;
    step();
    bus.pay = 1'b0;
    expect_tag("t6_new_tag", 7, 1, 1);
    step();
    check("t6_new_done", int'(bus.done), 1);
    check("t6_new_disc", int'(bus.disc_count), 1);
    step();
    expect_idle("t6_new_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
